// File: rtl/fingertip_locator.sv
// fingertip_locator: raster-order scan of a binary skin mask that reports, once
// per frame, the centre of the topmost horizontal skin run of at least MIN_RUN
// pixels. Optional build macro FT_HOLD_LAST_EN: when defined, a frame with no
// qualifying run keeps the previous coordinate/valid; otherwise they clear.
module fingertip_locator #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int MIN_RUN  = 4
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iSOF,
    input  logic       iDVAL,
    input  logic       iSkin,
    output logic [9:0] oFT_X,
    output logic [9:0] oFT_Y,
    output logic       oDVAL,
    output logic       oFrame_En
);

    localparam logic [9:0]  LAST_X  = 10'(H_ACTIVE - 1);
    localparam logic [9:0]  LAST_Y  = 10'(V_ACTIVE - 1);
    localparam logic [10:0] RUN_MAX = 11'(MIN_RUN);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        LOCKED
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic [10:0] run_len_q, run_len_d;
    logic [9:0]  run_start_q, run_start_d;
    logic        found_q, found_d;
    logic [9:0]  cand_x_q, cand_x_d;
    logic [9:0]  cand_y_q, cand_y_d;
    logic [9:0]  ft_x_q, ft_x_d;
    logic [9:0]  ft_y_q, ft_y_d;
    logic        dval_q, dval_d;
    logic        frame_en_q, frame_en_d;

    // Working copies of the frame position/run state after any start-of-frame
    // restart, so a pixel arriving together with iSOF is processed as (0,0).
    state_t      cur_state;
    logic [9:0]  cur_x;
    logic [9:0]  cur_y;
    logic [10:0] cur_len;
    logic [10:0] len_inc;
    logic [9:0]  start;
    logic [9:0]  run_end;
    logic [10:0] sum;
    logic        qualify;

    // Next-state logic: frame restart, run tracking, candidate capture, frame end.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        run_len_d   = run_len_q;
        run_start_d = run_start_q;
        found_d     = found_q;
        cand_x_d    = cand_x_q;
        cand_y_d    = cand_y_q;
        ft_x_d      = ft_x_q;
        ft_y_d      = ft_y_q;
        dval_d      = dval_q;
        frame_en_d  = 1'b0;

        cur_state = state_q;
        cur_x     = x_q;
        cur_y     = y_q;
        cur_len   = run_len_q;
        len_inc   = '0;
        start     = run_start_q;
        run_end   = x_q;
        sum       = '0;
        qualify   = 1'b0;

        // Start of frame restarts from (0,0) in any state, discarding a partial frame.
        if (iSOF) begin
            cur_state = SCAN;
            cur_x     = '0;
            cur_y     = '0;
            cur_len   = '0;
            state_d   = SCAN;
            x_d       = '0;
            y_d       = '0;
            run_len_d = '0;
            found_d   = 1'b0;
        end

        if (iDVAL && cur_state != IDLE) begin
            // A new row always begins a fresh run.
            if (cur_x == '0) begin
                cur_len = '0;
            end

            if (cur_state == SCAN) begin
                if (iSkin) begin
                    if (cur_len == '0) begin
                        start = cur_x;
                    end
                    len_inc     = (cur_len >= RUN_MAX) ? RUN_MAX : cur_len + 11'd1;
                    run_len_d   = len_inc;
                    run_start_d = start;
                    if (cur_x == LAST_X && len_inc >= RUN_MAX) begin
                        qualify = 1'b1;
                        run_end = cur_x;
                    end
                end else begin
                    run_len_d = '0;
                    if (cur_len >= RUN_MAX) begin
                        qualify = 1'b1;
                        run_end = cur_x - 10'd1;
                    end
                end

                if (qualify) begin
                    sum      = {1'b0, start} + {1'b0, run_end};
                    cand_x_d = 10'(sum >> 1);
                    cand_y_d = cur_y;
                    found_d  = 1'b1;
                    state_d  = LOCKED;
                end
            end

            if (cur_x == LAST_X) begin
                x_d = '0;
                y_d = cur_y + 10'd1;
            end else begin
                x_d = cur_x + 10'd1;
                y_d = cur_y;
            end

            // Final pixel: it has already been evaluated above, so a run ending
            // here is reported in this frame.
            if (cur_x == LAST_X && cur_y == LAST_Y) begin
                frame_en_d = 1'b1;
                state_d    = IDLE;
                if (found_d) begin
                    ft_x_d = cand_x_d;
                    ft_y_d = cand_y_d;
                    dval_d = 1'b1;
                end else begin
`ifndef FT_HOLD_LAST_EN
                    ft_x_d = '0;
                    ft_y_d = '0;
                    dval_d = 1'b0;
`endif
                end
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            run_len_q   <= '0;
            run_start_q <= '0;
            found_q     <= 1'b0;
            cand_x_q    <= '0;
            cand_y_q    <= '0;
            ft_x_q      <= '0;
            ft_y_q      <= '0;
            dval_q      <= 1'b0;
            frame_en_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            run_len_q   <= run_len_d;
            run_start_q <= run_start_d;
            found_q     <= found_d;
            cand_x_q    <= cand_x_d;
            cand_y_q    <= cand_y_d;
            ft_x_q      <= ft_x_d;
            ft_y_q      <= ft_y_d;
            dval_q      <= dval_d;
            frame_en_q  <= frame_en_d;
        end
    end

    assign oFT_X     = ft_x_q;
    assign oFT_Y     = ft_y_q;
    assign oDVAL     = dval_q;
    assign oFrame_En = frame_en_q;

endmodule

// File: tb/tb_fingertip_locator.sv
// Testbench for fingertip_locator on a reduced frame geometry; expectations
// come from a row-by-row run search over a stored pixel mask.
module tb_fingertip_locator;

    localparam int H  = 48;
    localparam int V  = 12;
    localparam int MR = 4;
    localparam int N  = H * V;

    logic       clk = 1'b0;
    logic       rst, sof, dval, skin;
    logic [9:0] ft_x, ft_y;
    logic       odval, fen;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    bit         mask [N];
    logic [9:0] exp_x, exp_y;
    logic       exp_dval;

    fingertip_locator #(.H_ACTIVE(H), .V_ACTIVE(V), .MIN_RUN(MR)) dut (
        .iCLK(clk), .iRST(rst), .iSOF(sof), .iDVAL(dval), .iSkin(skin),
        .oFT_X(ft_x), .oFT_Y(ft_y), .oDVAL(odval), .oFrame_En(fen)
    );

    always #5 clk = ~clk;

    // Count frame-enable pulses.
    always @(negedge clk) if (fen === 1'b1) pulses++;

    initial begin
        #2ms;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mask();
        foreach (mask[i]) mask[i] = 1'b0;
    endtask

    task automatic set_run(input int y, input int x0, input int x1);
        for (int x = x0; x <= x1; x++) mask[y*H + x] = 1'b1;
    endtask

    // Topmost qualifying run: scan each row for maximal skin segments.
    function automatic void ref_model(output bit f, output int fx, output int fy);
        f = 0; fx = 0; fy = 0;
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                if (mask[y*H + x] && (x == 0 || !mask[y*H + x - 1])) begin
                    int e = x;
                    while (e + 1 < H && mask[y*H + e + 1]) e++;
                    if (e - x + 1 >= MR) begin
                        f = 1; fx = (x + e) / 2; fy = y;
                        return;
                    end
                end
            end
        end
    endfunction

    task automatic send_pixels(input int from, input int to, input int gap, input bit first_sof);
        for (int p = from; p <= to; p++) begin
            while ($urandom_range(0, 99) < gap) begin
                dval = 1'b0; sof = 1'b0; skin = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            dval = 1'b1; skin = mask[p]; sof = first_sof && (p == from);
            @(negedge clk);
        end
        dval = 1'b0; sof = 1'b0; skin = 1'b0;
    endtask

    task automatic run_frame(input string tag, input int gap, input bit sof_alone);
        bit f; int fx, fy;
        if (sof_alone) begin
            sof = 1'b1; dval = 1'b0;
            @(negedge clk);
            sof = 1'b0;
        end
        send_pixels(0, N - 1, gap, !sof_alone);
        ref_model(f, fx, fy);
        if (f) begin
            exp_x = 10'(fx); exp_y = 10'(fy); exp_dval = 1'b1;
        end else begin
`ifndef FT_HOLD_LAST_EN
            exp_x = '0; exp_y = '0; exp_dval = 1'b0;
`endif
        end
        chk({tag, ".fen"},  32'(fen),   1);
        chk({tag, ".x"},    32'(ft_x),  32'(exp_x));
        chk({tag, ".y"},    32'(ft_y),  32'(exp_y));
        chk({tag, ".dval"}, 32'(odval), 32'(exp_dval));
        @(negedge clk);
        chk({tag, ".fen_off"}, 32'(fen),  0);
        chk({tag, ".x_hold"},  32'(ft_x), 32'(exp_x));
    endtask

    initial begin
        int p;
        rst = 1'b1; sof = 1'b0; dval = 1'b0; skin = 1'b0;
        exp_x = '0; exp_y = '0; exp_dval = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst.x", 32'(ft_x), 0);
        chk("rst.y", 32'(ft_y), 0);
        chk("rst.dval", 32'(odval), 0);
        chk("rst.fen", 32'(fen), 0);

        // Valid pixels before any start of frame are ignored.
        clear_mask(); set_run(2, 4, 20);
        send_pixels(0, N - 1, 0, 1'b0);
        @(negedge clk);
        chk("pre_sof.pulses", 32'(pulses), 0);
        chk("pre_sof.dval", 32'(odval), 0);

        clear_mask(); set_run(10, 20, 29);
        run_frame("basic", 0, 1'b0);
        chk("basic.x_const", 32'(ft_x), 24);

        clear_mask();
        run_frame("empty", 0, 1'b0);

        clear_mask(); set_run(3, 10, 12); set_run(5, 10, 15);
        run_frame("short_run", 0, 1'b0);

        clear_mask(); set_run(1, 44, 47); set_run(8, 0, 30);
        run_frame("row_end", 0, 1'b1);

        clear_mask(); set_run(2, 45, 47); set_run(11, 44, 47);
        run_frame("last_pixel", 0, 1'b0);

        clear_mask(); set_run(0, 0, 3);
        run_frame("origin", 10, 1'b0);

        // Abort a partial (already locked) frame with a new start of frame.
        clear_mask(); set_run(0, 5, 12);
        send_pixels(0, 99, 10, 1'b1);
        p = pulses;
        clear_mask(); set_run(7, 30, 37);
        run_frame("abort", 25, 1'b0);
        @(negedge clk);
        chk("abort.pulses", 32'(pulses), 32'(p + 1));

        // Pixels after completion without a new start of frame.
        p = pulses;
        send_pixels(0, N - 1, 0, 1'b0);
        @(negedge clk);
        chk("post_done.pulses", 32'(pulses), 32'(p));
        chk("post_done.x", 32'(ft_x), 32'(exp_x));

        for (int f = 0; f < 5; f++) begin
            clear_mask();
            for (int y = 0; y < V; y++) begin
                if ($urandom_range(0, 99) < 25) begin
                    int x0 = $urandom_range(0, H - 1);
                    int len = $urandom_range(1, 7);
                    set_run(y, x0, (x0 + len - 1 > H - 1) ? H - 1 : x0 + len - 1);
                end
            end
            run_frame($sformatf("rand%0d", f), 20, 1'(f % 2));
        end

        // Reset mid-frame, after a lock, coinciding with a start of frame.
        clear_mask(); set_run(10, 20, 29);
        run_frame("pre_rst", 0, 1'b0);
        clear_mask(); set_run(0, 2, 9);
        send_pixels(0, 2 * H, 0, 1'b1);
        rst = 1'b1; sof = 1'b1; dval = 1'b1; skin = 1'b1;
        @(negedge clk);
        rst = 1'b0; sof = 1'b0; dval = 1'b0; skin = 1'b0;
        exp_x = '0; exp_y = '0; exp_dval = 1'b0;
        chk("mid_rst.x", 32'(ft_x), 0);
        chk("mid_rst.y", 32'(ft_y), 0);
        chk("mid_rst.dval", 32'(odval), 0);
        chk("mid_rst.fen", 32'(fen), 0);
        p = pulses;
        send_pixels(0, N - 1, 0, 1'b0);
        @(negedge clk);
        chk("mid_rst.pulses", 32'(pulses), 32'(p));
        chk("mid_rst.dval_hold", 32'(odval), 0);

        run_frame("post_rst", 15, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fingertip_locator.md
# fingertip_locator

Scans the binary skin-mask pixel stream in raster order and, once per frame, reports the fingertip coordinate: the centre of the first sufficiently long horizontal skin run, which is the topmost one. It drives the fingertip X/Y, valid and frame-enable interface consumed by the movement-detection stage, which maps the coordinate to a tic-tac-toe grid cell. It sits between the skin-segmentation filter and movement detection in the IPU.

## Interface
- H_ACTIVE, 640, pixels per row
- V_ACTIVE, 480, rows per frame
- MIN_RUN, 4, minimum consecutive skin pixels that qualify as a fingertip (range 1..H_ACTIVE)
- iCLK  input  1  pixel clock, rising edge
- iRST  input  1  reset; synchronous, active-high
- iSOF  input  1  start of frame; a single-cycle pulse on the cycle of pixel (0,0)
- iDVAL  input  1  pixel valid
- iSkin  input  1  mask pixel: 1 = skin; sampled only when iDVAL=1
- oFT_X  output  10  fingertip column
- oFT_Y  output  10  fingertip row
- oDVAL  output  1  oFT_X/oFT_Y hold a valid fingertip
- oFrame_En  output  1  one-cycle pulse: coordinates updated for the completed frame

## Operation
- Internal counters:
  - x is 10 bits and y is 10 bits.
  - Both advance only on cycles with iDVAL=1.
  - x wraps from H_ACTIVE-1 to 0 and increments y.
- States:
  - IDLE:
    - Pixels are ignored.
    - iSOF&iDVAL treats that pixel as (0,0) and enters SCAN.
    - iSOF without iDVAL clears x/y and enters SCAN; the next valid pixel is (0,0).
  - SCAN:
    - run_len counts consecutive skin pixels in the current row and saturates at MIN_RUN.
    - run_start latches x on the first skin pixel of a run.
    - A non-skin pixel resets run_len, and so does x=0 (a new row).
    - When run_len has reached MIN_RUN and the run terminates, the block latches cand_x = (run_start + run_end) >> 1 and cand_y = y, sets found, and enters LOCKED.
      - Run termination is a non-skin pixel, or the skin pixel at x=H_ACTIVE-1.
      - run_end is the last skin x of the run.
      - The sum is computed in 11 bits and then truncated.
  - LOCKED:
    - Pixels are counted only; no further runs are evaluated.
- Frame completion:
  - Triggered by the pixel at (H_ACTIVE-1, V_ACTIVE-1) accepted in SCAN or LOCKED.
  - That pixel is evaluated first, so a run ending exactly there qualifies.
  - On the next cycle:
    - oFrame_En=1.
    - If found: oFT_X=cand_x, oFT_Y=cand_y, oDVAL=1.
    - Miss (no found): see Configuration.
  - The state then returns to IDLE.
- Abort: iSOF while in SCAN or LOCKED discards the partial frame and restarts at (0,0).
  - No oFrame_En is generated for the discarded frame.
  - Outputs are unchanged.
- Pixels after frame completion without a new iSOF are ignored, because the state is IDLE.
- Reset:
  - iRST at any time, including mid-frame, forces the state to IDLE.
  - Counters, run_len, found and candidates are cleared to 0.
  - Reset values: oFT_X=0, oFT_Y=0, oDVAL=0, oFrame_En=0.
  - iRST dominates iSOF in the same cycle.

## Timing
- Latency: oFrame_En rises exactly 1 cycle after the final pixel is accepted and lasts exactly 1 cycle.
- oFT_X, oFT_Y and oDVAL change only in that same cycle, or on reset. They are stable between pulses.
- iDVAL gaps are allowed anywhere; they stall x/y and do not break a run.
- iSkin is a don't-care when iDVAL=0.
- All outputs are registered. There is no combinational input-to-output path.

## Configuration
- FT_HOLD_LAST_EN
  - Defined: on a miss frame, oFT_X, oFT_Y and oDVAL keep their previous values; oFrame_En still pulses.
  - Undefined: on a miss frame, oFT_X=0, oFT_Y=0 and oDVAL=0, with oFrame_En pulsing.

## Test plan
- Default parameters; skin only at row 100, x 200..209; full frame -> one cycle after pixel (639,479):
  - oFrame_En=1 for 1 cycle.
  - oFT_X=204, oFT_Y=100, oDVAL=1.
- Row 50, x 10..12 (run of 3 < MIN_RUN) plus row 60, x 10..15 -> oFT_X=12, oFT_Y=60. The row-50 run is ignored.
- Row 5, x 636..639 (run reaching row end) plus row 200, x 0..99 -> oFT_X=637, oFT_Y=5. The later run is ignored (LOCKED).
- Empty frame after the frame of the first scenario:
  - Macro undefined -> oDVAL=0, oFT_X=0, oFT_Y=0.
  - Macro defined -> oFT_X=204, oFT_Y=100, oDVAL=1.
  - oFrame_En pulses in both cases.
- Abort and ignore handling:
  - Setup: iSOF at pixel 1000 of a frame, then a full clean frame with skin at row 300, x 400..407, with random iDVAL gaps.
  - Response: exactly one oFrame_En, with oFT_X=403, oFT_Y=300.
  - Valid pixels arriving before the first iSOF produce no pulse.
- Reset handling:
  - Stimulus: iRST asserted mid-frame, after a run has locked, in the same cycle as iSOF.
  - Response: next cycle all outputs are 0 and the state is IDLE.
  - Remaining pixels of that frame produce no oFrame_En.
